// File: rtl/predictor_update_ctrl_pkg.sv
// predictor_update_ctrl_pkg: shared constants and types for the predictor update controller
package predictor_update_ctrl_pkg;
   localparam int PRED_UPD_FIFO_DEPTH = 4;
   localparam int PREDICTOR_IDX_W = 8;
   localparam int ADDR_W_DEF = 32;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
   localparam logic TRUE = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic [1:0] WEAK_NOT_JUMP = 2'b01;
   localparam logic [0:0] CTRL_IDLE = 1'b0;
   localparam logic [0:0] CTRL_CLEAR = 1'b1;
endpackage

// File: rtl/predictor_update_ctrl_if.sv
// predictor_update_ctrl_if: ROB update handshake, clear request and predictor write port
interface predictor_update_ctrl_if
   import predictor_update_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IDX_W = PREDICTOR_IDX_W
);
   logic              upd_valid_from_rob;
   logic [ADDR_W-1:0] upd_pc_from_rob;
   logic              upd_jump_from_rob;
   logic              upd_ready_to_rob;
   logic              clear_req;
   logic              enable_sign_to_pred;
   logic              jump_sign_to_pred;
   logic [ADDR_W-1:0] pc_to_pred;
   logic              clear_en_to_pred;
   logic [IDX_W-1:0]  clear_idx_to_pred;
   logic              clear_busy;
   logic              clear_done;
   modport master (
      input  upd_valid_from_rob, upd_pc_from_rob, upd_jump_from_rob, clear_req,
      output upd_ready_to_rob, enable_sign_to_pred, jump_sign_to_pred, pc_to_pred,
             clear_en_to_pred, clear_idx_to_pred, clear_busy, clear_done
   );
   modport slave (
      output upd_valid_from_rob, upd_pc_from_rob, upd_jump_from_rob, clear_req,
      input  upd_ready_to_rob, enable_sign_to_pred, jump_sign_to_pred, pc_to_pred,
             clear_en_to_pred, clear_idx_to_pred, clear_busy, clear_done
   );
endinterface

// File: rtl/predictor_update_ctrl_fifo.sv
// pred_upd_fifo: generic synchronous circular FIFO with head-of-queue read (active-low sync reset)
module pred_upd_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 33
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d;
   assign dout_o = mem_q[head_q];
   assign count_o = count_q;
   // pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth
   always_comb begin
      head_d = pop_i ? head_q + 1'b1 : head_q;
      tail_d = push_i ? tail_q + 1'b1 : tail_q;
      count_d = (push_i && !pop_i) ? count_q + 1'b1 : (!push_i && pop_i) ? count_q - 1'b1 : count_q;
   end
   // pointer/count registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
      end
   end
   // storage needs no reset: entries are only read while counted as valid
   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= din_i;
   end
endmodule

// File: rtl/predictor_update_ctrl.sv
// predictor_update_ctrl: queues ROB branch updates and sequences the predictor write/clear port; PRED_UPD_BYPASS_EN enables zero-latency bypass
module predictor_update_ctrl
   import predictor_update_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = PRED_UPD_FIFO_DEPTH,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int IDX_W = PREDICTOR_IDX_W
) (
   input logic clk,
   input logic rst,
   predictor_update_ctrl_if.master bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [CW-1:0]    count;
   logic [ADDR_W:0]  head;
   logic             idle, ready, push_acc, byp, pop, fifo_push;
   assign idle = state_q == CTRL_IDLE;
   assign ready = rst && (count != CW'(FIFO_DEPTH));
   assign push_acc = bus.upd_valid_from_rob && ready;
`ifdef PRED_UPD_BYPASS_EN
   assign byp = idle && (count == '0) && push_acc;
`else
   assign byp = FALSE;
`endif
   assign pop = idle && (count != '0);
   assign fifo_push = push_acc && !byp;
   pred_upd_fifo #(.DEPTH(FIFO_DEPTH), .W(ADDR_W + 1)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (pop),
      .din_i   ({bus.upd_pc_from_rob, bus.upd_jump_from_rob}),
      .dout_o  (head),
      .count_o (count)
   );
   // predictor-facing outputs; update and clear strobes are mutually exclusive by state
   always_comb begin
      bus.upd_ready_to_rob = ready;
      bus.enable_sign_to_pred = pop || byp;
      {bus.pc_to_pred, bus.jump_sign_to_pred} = pop ? head : byp ? {bus.upd_pc_from_rob, bus.upd_jump_from_rob} : '0;
      bus.clear_en_to_pred = !idle;
      bus.clear_idx_to_pred = idle ? '0 : cnt_q;
      bus.clear_busy = !idle;
      bus.clear_done = done_q;
   end
   // sweep sequencing: start on request in IDLE, walk every index, pulse done on exit
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      done_d = FALSE;
      if (idle) begin
         if (bus.clear_req) begin
            state_d = CTRL_CLEAR;
            cnt_d = '0;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_d = CTRL_IDLE;
            done_d = TRUE;
         end
      end
   end
   // controller state registers; reset aborts any sweep without a done pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CTRL_IDLE;
         cnt_q <= '0;
         done_q <= FALSE;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         done_q <= done_d;
      end
   end
endmodule

// File: tb/tb_predictor_update_ctrl.sv
// tb_predictor_update_ctrl: randomized bench with a queue-based reference model
module tb_predictor_update_ctrl;
   localparam int DEPTH = 4;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int LAST = (1 << IW) - 1;
   typedef struct {logic [AW-1:0] pc; logic jump;} upd_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   predictor_update_ctrl_if #(.ADDR_W(AW), .IDX_W(IW)) bus ();
   predictor_update_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .IDX_W(IW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   upd_t mq[$];
   bit   m_clr = 1'b0;
   bit   m_done = 1'b0;
   int   m_idx = 0;
   int   checks = 0;
   int   errors = 0;
   int   obs_done = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input bit v, input logic [AW-1:0] pc, input bit j, input bit cr, input bit rn, input bit check);
      bit rdy, byp, en;
      logic [AW-1:0] epc;
      bit ej;
      upd_t e;
      bus.upd_valid_from_rob = v;
      bus.upd_pc_from_rob = pc;
      bus.upd_jump_from_rob = j;
      bus.clear_req = cr;
      rst = rn;
      @(negedge clk);
      rdy = rn && (mq.size() < DEPTH);
      byp = 1'b0;
`ifdef PRED_UPD_BYPASS_EN
      byp = !m_clr && (mq.size() == 0) && v && rdy;
`endif
      en = !m_clr && ((mq.size() != 0) || byp);
      epc = '0;
      ej = 1'b0;
      if (en && mq.size() != 0) begin
         epc = mq[0].pc;
         ej = mq[0].jump;
      end else if (en) begin
         epc = pc;
         ej = j;
      end
      if (check) begin
         chk("ready", bus.upd_ready_to_rob, rdy);
         chk("enable", bus.enable_sign_to_pred, en);
         chk("pc", bus.pc_to_pred, epc);
         chk("jump", bus.jump_sign_to_pred, ej);
         chk("clear_en", bus.clear_en_to_pred, m_clr);
         chk("clear_idx", bus.clear_idx_to_pred, m_clr ? m_idx : 0);
         chk("clear_busy", bus.clear_busy, m_clr);
         chk("clear_done", bus.clear_done, m_done);
         chk("exclusive", bus.clear_en_to_pred && bus.enable_sign_to_pred, 0);
         if (bus.clear_done === 1'b1) obs_done++;
      end
      @(posedge clk);
      if (!rn) begin
         mq.delete();
         m_clr = 1'b0;
         m_idx = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (en && !byp) void'(mq.pop_front());
         if (v && rdy && !byp) begin
            e.pc = pc;
            e.jump = j;
            mq.push_back(e);
         end
         if (m_clr) begin
            if (m_idx == LAST) begin
               m_clr = 1'b0;
               m_idx = 0;
               m_done = 1'b1;
            end else m_idx++;
         end else if (cr) begin
            m_clr = 1'b1;
            m_idx = 0;
         end
      end
      #1;
   endtask
   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask
   initial begin
      int d0;
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'h1000, 1'b1, 1'b0, 1'b1, 1'b1);
      idle_n(3);
      for (int k = 0; k < 5; k++) step(1'b1, $urandom, 1'($urandom), 1'b0, 1'b1, 1'b1);
      idle_n(3);
      d0 = obs_done;
      for (int k = 0; k < 270; k++)
         step(k >= 1 && k <= 6, $urandom, 1'($urandom), k == 0 || k == 101, 1'b1, 1'b1);
      chk("sweep_dones", obs_done - d0, 1);
      idle_n(4);
      d0 = obs_done;
      for (int k = 0; k < 53; k++)
         step(k == 1 || k == 2 || k >= 51, $urandom, 1'($urandom), k == 0, k < 51, 1'b1);
      idle_n(300);
      chk("abort_dones", obs_done - d0, 0);
`ifdef PRED_UPD_BYPASS_EN
      step(1'b1, 32'h2004, 1'b0, 1'b0, 1'b1, 1'b1);
      idle_n(2);
`endif
      for (int k = 0; k < 3000; k++)
         step(1'($urandom), $urandom, 1'($urandom), $urandom_range(0, 299) == 0, $urandom_range(0, 799) != 0, 1'b1);
      idle_n(270);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
